// File: rtl/prefetch_decoder_if.sv
// rtl/prefetch_decoder_if.sv - code-bus and opcode-packet signals of the prefetch decoder
// master = decoder side, slave = memory/exec side.
interface prefetch_decoder_if #(
  parameter int BUS_BYTES = 1
);
  logic [31:0]              mem_addr;
  logic                     mem_req;
  logic                     mem_ack;
  logic [8*BUS_BYTES-1:0]   mem_in;
  logic                     op_valid;
  logic                     op_ready;
  logic [1:0]               op_kind;
  logic [8:0]               op_code;
  logic [7:0]               op_vec;
  logic [1:0]               op_rep;
  logic [2:0]               op_seg;
  logic                     op_ovr;
  logic                     op_opsize;
  logic                     op_adsize;
  logic                     op_lock;
  logic [15:0]              op_ip;
  logic [15:0]              op_ip_next;

  modport master (
    output mem_addr, mem_req,
    input  mem_ack, mem_in,
    output op_valid,
    input  op_ready,
    output op_kind, op_code, op_vec, op_rep, op_seg, op_ovr,
    output op_opsize, op_adsize, op_lock, op_ip, op_ip_next
  );

  modport slave (
    input  mem_addr, mem_req,
    output mem_ack, mem_in,
    input  op_valid,
    output op_ready,
    input  op_kind, op_code, op_vec, op_rep, op_seg, op_ovr,
    input  op_opsize, op_adsize, op_lock, op_ip, op_ip_next
  );
endinterface

// File: rtl/prefetch_decoder.sv
// rtl/prefetch_decoder.sv - x86 prefetch queue with prefix parser and opcode packet output
// Optional macro FETCH_TRACE_EN enables single-step trace packets (kind 2).
module prefetch_decoder #(
  parameter int          BUS_BYTES  = 1,
  parameter int          DEPTH      = 8,
  parameter int          MAX_PREFIX = 14,
  parameter logic [15:0] RESET_IP   = 16'h0000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        cs_base,
  input  logic               flush,
  input  logic [15:0]        flush_ip,
  input  logic               if_flag,
  input  logic               tf_flag,
  input  logic               intr,
  input  logic [7:0]         irq,
  output logic               intl,
  prefetch_decoder_if.master bus
);
  localparam int          AW         = $clog2(DEPTH);
  localparam int          CW         = $clog2(DEPTH + 1);
  localparam int          PW         = $clog2(MAX_PREFIX + 2);
  localparam logic [15:0] ALIGN_MASK = 16'(BUS_BYTES - 1);

  typedef enum logic {RUN, HOLD} state_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return b inside {8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65,
                     8'hF0, 8'hF2, 8'hF3, 8'h66, 8'h67, 8'h0F};
  endfunction

  logic [7:0]    queue_q [DEPTH];
  logic [7:0]    queue_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   fetch_ip_q, fetch_ip_d;
  logic          req_q, req_d, discard_q, discard_d;
  logic [31:0]   addr_q, addr_d;
  state_t        state_q, state_d;
  logic [15:0]   ip_q, ip_d, first_ip_q, first_ip_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [2:0]    p_seg_q, p_seg_d;
  logic [1:0]    p_rep_q, p_rep_d;
  logic          p_ovr_q, p_ovr_d, p_opsize_q, p_opsize_d;
  logic          p_adsize_q, p_adsize_d, p_lock_q, p_lock_d, p_of_q, p_of_d;
  logic          ov_q, ov_d;
  logic [1:0]    kind_q, kind_d, rep_q, rep_d;
  logic [8:0]    code_q, code_d;
  logic [7:0]    vec_q, vec_d;
  logic [2:0]    seg_q, seg_d;
  logic          ovr_q, ovr_d, opsize_q, opsize_d, adsize_q, adsize_d, lock_q, lock_d;
  logic [15:0]   opip_q, opip_d, opipn_q, opipn_d;
  logic          intl_q, intl_d;
`ifdef FETCH_TRACE_EN
  logic          trace_q, trace_d;
`else
  logic          unused_tf;
  assign unused_tf = tf_flag;
`endif

  logic [CW-1:0] enq;
  logic          deq, emit;
  logic [1:0]    emit_kind;
  logic [7:0]    emit_vec, head_b;
  logic [8:0]    emit_code;
  logic [15:0]   emit_ipn, pkt_ip, off;

  always_comb begin
    queue_d    = queue_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fetch_ip_d = fetch_ip_q;
    req_d      = req_q;
    discard_d  = discard_q;
    addr_d     = addr_q;
    state_d    = state_q;
    ip_d       = ip_q;
    first_ip_d = first_ip_q;
    pcnt_d     = pcnt_q;
    p_seg_d    = p_seg_q;
    p_rep_d    = p_rep_q;
    p_ovr_d    = p_ovr_q;
    p_opsize_d = p_opsize_q;
    p_adsize_d = p_adsize_q;
    p_lock_d   = p_lock_q;
    p_of_d     = p_of_q;
    ov_d       = ov_q;
    kind_d     = kind_q;
    code_d     = code_q;
    vec_d      = vec_q;
    rep_d      = rep_q;
    seg_d      = seg_q;
    ovr_d      = ovr_q;
    opsize_d   = opsize_q;
    adsize_d   = adsize_q;
    lock_d     = lock_q;
    opip_d     = opip_q;
    opipn_d    = opipn_q;
    intl_d     = intl_q;
`ifdef FETCH_TRACE_EN
    trace_d    = trace_q;
`endif
    enq        = '0;
    deq        = 1'b0;
    emit       = 1'b0;
    emit_kind  = 2'd0;
    emit_vec   = 8'h00;
    emit_code  = 9'h000;
    emit_ipn   = ip_q + 16'd1;
    off        = fetch_ip_q & ALIGN_MASK;
    head_b     = queue_q[head_q];
    pkt_ip     = (pcnt_q != '0) ? first_ip_q : ip_q;

    // Only the first beat after a restart can start mid-word; its leading bytes are dropped.
    if (req_q && bus.mem_ack) begin
      req_d     = 1'b0;
      discard_d = 1'b0;
      if (!discard_q) begin
        for (int i = 0; i < BUS_BYTES; i++) begin
          if (16'(i) >= off && (count_q + enq) < CW'(DEPTH)) begin
            queue_d[tail_q + AW'(enq)] = bus.mem_in[8*i +: 8];
            enq = enq + CW'(1);
          end
        end
        tail_d     = tail_q + AW'(enq);
        fetch_ip_d = (fetch_ip_q & ~ALIGN_MASK) + 16'(BUS_BYTES);
      end
    end else if (!req_q && (CW'(DEPTH) - count_q) >= CW'(BUS_BYTES)) begin
      req_d  = 1'b1;
      addr_d = cs_base + {16'h0000, fetch_ip_q & ~ALIGN_MASK};
    end

    if (ov_q && bus.op_ready) ov_d = 1'b0;

    if (state_q == RUN && count_q != '0 && (!ov_q || bus.op_ready)) begin
      if (is_prefix(head_b)) begin
        deq    = 1'b1;
        ip_d   = ip_q + 16'd1;
        pcnt_d = pcnt_q + PW'(1);
        if (pcnt_q == '0) first_ip_d = ip_q;
        case (head_b)
          8'h26: begin p_seg_d = 3'd0; p_ovr_d = 1'b1; end
          8'h2E: begin p_seg_d = 3'd1; p_ovr_d = 1'b1; end
          8'h36: begin p_seg_d = 3'd2; p_ovr_d = 1'b1; end
          8'h3E: begin p_seg_d = 3'd3; p_ovr_d = 1'b1; end
          8'h64: begin p_seg_d = 3'd4; p_ovr_d = 1'b1; end
          8'h65: begin p_seg_d = 3'd5; p_ovr_d = 1'b1; end
          8'hF2: p_rep_d    = 2'b10;
          8'hF3: p_rep_d    = 2'b11;
          8'hF0: p_lock_d   = 1'b1;
          8'h66: p_opsize_d = 1'b1;
          8'h67: p_adsize_d = 1'b1;
          default: p_of_d   = 1'b1;
        endcase
        if (pcnt_q == PW'(MAX_PREFIX)) begin
          emit      = 1'b1;
          emit_kind = 2'd3;
          state_d   = HOLD;
        end
      end else if (if_flag && (intr ^ intl_q)) begin
        // Interrupt is taken before the opcode byte, which stays queued.
        emit      = 1'b1;
        emit_kind = 2'd1;
        emit_vec  = irq;
        emit_ipn  = ip_q;
        intl_d    = intr;
        state_d   = HOLD;
      end
`ifdef FETCH_TRACE_EN
      else if (tf_flag && trace_q) begin
        emit      = 1'b1;
        emit_kind = 2'd2;
        emit_vec  = 8'h01;
        emit_ipn  = ip_q;
        trace_d   = 1'b0;
        state_d   = HOLD;
      end
`endif
      else begin
        deq       = 1'b1;
        ip_d      = ip_q + 16'd1;
        emit      = 1'b1;
        emit_code = {p_of_q, head_b};
`ifdef FETCH_TRACE_EN
        if (tf_flag) trace_d = ~trace_q;
`endif
      end
    end

    if (emit) begin
      ov_d       = 1'b1;
      kind_d     = emit_kind;
      code_d     = emit_code;
      vec_d      = emit_vec;
      rep_d      = p_rep_q;
      seg_d      = p_seg_q;
      ovr_d      = p_ovr_q;
      opsize_d   = p_opsize_q;
      adsize_d   = p_adsize_q;
      lock_d     = p_lock_q;
      opip_d     = pkt_ip;
      opipn_d    = emit_ipn;
      pcnt_d     = '0;
      p_seg_d    = 3'd3;
      p_rep_d    = 2'b00;
      p_ovr_d    = 1'b0;
      p_opsize_d = 1'b0;
      p_adsize_d = 1'b0;
      p_lock_d   = 1'b0;
      p_of_d     = 1'b0;
    end

    head_d  = head_q + AW'(deq);
    count_d = count_q + enq - CW'(deq);

    // A request still in flight must complete; its data is marked stale.
    if (flush) begin
      req_d      = req_q && !bus.mem_ack;
      discard_d  = req_q && !bus.mem_ack;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      ov_d       = 1'b0;
      intl_d     = intl_q;
`ifdef FETCH_TRACE_EN
      trace_d    = trace_q;
`endif
      fetch_ip_d = flush_ip;
      ip_d       = flush_ip;
      state_d    = RUN;
      pcnt_d     = '0;
      p_seg_d    = 3'd3;
      p_rep_d    = 2'b00;
      p_ovr_d    = 1'b0;
      p_opsize_d = 1'b0;
      p_adsize_d = 1'b0;
      p_lock_d   = 1'b0;
      p_of_d     = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) queue_q[i] <= 8'h00;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_ip_q <= RESET_IP;
      req_q      <= 1'b0;
      discard_q  <= 1'b0;
      addr_q     <= 32'h0;
      state_q    <= RUN;
      ip_q       <= RESET_IP;
      first_ip_q <= RESET_IP;
      pcnt_q     <= '0;
      p_seg_q    <= 3'd3;
      p_rep_q    <= 2'b00;
      p_ovr_q    <= 1'b0;
      p_opsize_q <= 1'b0;
      p_adsize_q <= 1'b0;
      p_lock_q   <= 1'b0;
      p_of_q     <= 1'b0;
      ov_q       <= 1'b0;
      kind_q     <= 2'd0;
      code_q     <= 9'h000;
      vec_q      <= 8'h00;
      rep_q      <= 2'b00;
      seg_q      <= 3'd3;
      ovr_q      <= 1'b0;
      opsize_q   <= 1'b0;
      adsize_q   <= 1'b0;
      lock_q     <= 1'b0;
      opip_q     <= 16'h0000;
      opipn_q    <= 16'h0000;
      intl_q     <= 1'b0;
`ifdef FETCH_TRACE_EN
      trace_q    <= 1'b0;
`endif
    end else begin
      queue_q    <= queue_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_ip_q <= fetch_ip_d;
      req_q      <= req_d;
      discard_q  <= discard_d;
      addr_q     <= addr_d;
      state_q    <= state_d;
      ip_q       <= ip_d;
      first_ip_q <= first_ip_d;
      pcnt_q     <= pcnt_d;
      p_seg_q    <= p_seg_d;
      p_rep_q    <= p_rep_d;
      p_ovr_q    <= p_ovr_d;
      p_opsize_q <= p_opsize_d;
      p_adsize_q <= p_adsize_d;
      p_lock_q   <= p_lock_d;
      p_of_q     <= p_of_d;
      ov_q       <= ov_d;
      kind_q     <= kind_d;
      code_q     <= code_d;
      vec_q      <= vec_d;
      rep_q      <= rep_d;
      seg_q      <= seg_d;
      ovr_q      <= ovr_d;
      opsize_q   <= opsize_d;
      adsize_q   <= adsize_d;
      lock_q     <= lock_d;
      opip_q     <= opip_d;
      opipn_q    <= opipn_d;
      intl_q     <= intl_d;
`ifdef FETCH_TRACE_EN
      trace_q    <= trace_d;
`endif
    end
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_req    = req_q;
  assign bus.op_valid   = ov_q;
  assign bus.op_kind    = kind_q;
  assign bus.op_code    = code_q;
  assign bus.op_vec     = vec_q;
  assign bus.op_rep     = rep_q;
  assign bus.op_seg     = seg_q;
  assign bus.op_ovr     = ovr_q;
  assign bus.op_opsize  = opsize_q;
  assign bus.op_adsize  = adsize_q;
  assign bus.op_lock    = lock_q;
  assign bus.op_ip      = opip_q;
  assign bus.op_ip_next = opipn_q;
  assign intl           = intl_q;
endmodule

// File: tb/tb_prefetch_decoder.sv
// tb/tb_prefetch_decoder.sv - directed self-checking bench for prefetch_decoder
// Runs with BUS_BYTES=2, DEPTH=8, MAX_PREFIX=14; trace expectations follow FETCH_TRACE_EN.
module tb_prefetch_decoder;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] cs_base;
  logic        flush;
  logic [15:0] flush_ip;
  logic        if_flag, tf_flag, intr;
  logic [7:0]  irq;
  logic        intl;
  logic        mem_stall;
  logic [7:0]  mem [0:255];

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int base   = 0;

  typedef struct packed {
    logic [1:0]  kind;
    logic [8:0]  code;
    logic [7:0]  vec;
    logic [1:0]  rep;
    logic [2:0]  seg;
    logic        ovr, opsize, adsize, lock;
    logic [15:0] ip, ipn;
  } pkt_t;
  pkt_t pk[$];

  always #5 clock = ~clock;

  prefetch_decoder_if #(.BUS_BYTES(2)) bus ();

  prefetch_decoder #(
    .BUS_BYTES(2), .DEPTH(8), .MAX_PREFIX(14), .RESET_IP(16'h0000)
  ) dut (
    .clock(clock), .reset(reset), .cs_base(cs_base), .flush(flush),
    .flush_ip(flush_ip), .if_flag(if_flag), .tf_flag(tf_flag), .intr(intr),
    .irq(irq), .intl(intl), .bus(bus)
  );

  // Memory answers one cycle after a request is seen, unless stalled.
  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_in  = 16'h0000;
    forever begin
      @(negedge clock);
      if (bus.mem_ack) bus.mem_ack = 1'b0;
      else if (bus.mem_req && !mem_stall) begin
        bus.mem_ack = 1'b1;
        bus.mem_in  = {mem[bus.mem_addr[7:0] + 8'd1], mem[bus.mem_addr[7:0]]};
      end
    end
  end

  always @(negedge clock) begin
    pkt_t t;
    #2;
    if (bus.op_valid && bus.op_ready) begin
      t.kind = bus.op_kind;     t.code = bus.op_code;     t.vec = bus.op_vec;
      t.rep = bus.op_rep;       t.seg = bus.op_seg;       t.ovr = bus.op_ovr;
      t.opsize = bus.op_opsize; t.adsize = bus.op_adsize; t.lock = bus.op_lock;
      t.ip = bus.op_ip;         t.ipn = bus.op_ip_next;
      pk.push_back(t);
    end
  end

  function automatic pkt_t pkt(input int i);
    return pk[base + i];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_flush(input logic [15:0] ip);
    flush_ip = ip;
    flush    = 1'b1;
    cyc(1);
    flush    = 1'b0;
    base     = pk.size();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b1; flush_ip = 16'h0001; cs_base = 32'h0;
    if_flag = 1'b0; tf_flag = 1'b0; intr = 1'b0; irq = 8'h00; mem_stall = 1'b0;
    bus.op_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h90;
    mem[8'h00] = 8'h40; mem[8'h01] = 8'h26; mem[8'h02] = 8'hF3; mem[8'h03] = 8'hA4;
    mem[8'h04] = 8'h0F; mem[8'h05] = 8'h84; mem[8'h06] = 8'h66; mem[8'h07] = 8'h67;
    mem[8'h08] = 8'hF0; mem[8'h09] = 8'h90;
    for (int i = 0; i < 22; i++) mem[8'h0A + i] = 8'h40 + 8'(i);
    mem[8'h80] = 8'h2E; mem[8'h81] = 8'h40; mem[8'h82] = 8'h41; mem[8'h83] = 8'h42;
    for (int i = 0; i < 15; i++) mem[8'hA0 + i] = 8'h26;
    mem[8'hAF] = 8'h40;
    for (int i = 0; i < 16; i++) begin
      mem[8'hC0 + i] = 8'h50 + 8'(i);
      mem[8'hD0 + i] = 8'h60 + 8'(i);
      mem[8'hE0 + i] = 8'h40 + 8'(i);
    end

    cyc(3);
    check("rst_op_valid", 32'(bus.op_valid), 32'd0);
    check("rst_mem_req",  32'(bus.mem_req),  32'd0);
    check("rst_intl",     32'(intl),         32'd0);
    check("rst_op_seg",   32'(bus.op_seg),   32'd3);
    check("rst_op_kind",  32'(bus.op_kind),  32'd0);
    check("rst_op_code",  32'(bus.op_code),  32'd0);
    check("rst_op_ip",    32'(bus.op_ip),    32'd0);

    reset = 1'b0;
    cyc(1);
    flush = 1'b0;
    cyc(40);
    check("bp_mem_req_stopped", 32'(bus.mem_req),    32'd0);
    check("bp_op_valid",        32'(bus.op_valid),   32'd1);
    check("bp_none_accepted",   32'(pk.size()),      32'd0);
    check("p0_kind",            32'(bus.op_kind),    32'd0);
    check("p0_code",            32'(bus.op_code),    32'h0A4);
    check("p0_seg",             32'(bus.op_seg),     32'd0);
    check("p0_ovr",             32'(bus.op_ovr),     32'd1);
    check("p0_rep",             32'(bus.op_rep),     32'd3);
    check("p0_ip",              32'(bus.op_ip),      32'h0001);
    check("p0_ip_next",         32'(bus.op_ip_next), 32'h0004);

    bus.op_ready = 1'b1;
    cyc(60);
    check("stream_count_ge13", 32'(pk.size() >= 13), 32'd1);
    check("s0_code",   32'(pkt(0).code),   32'h0A4);
    check("s1_code",   32'(pkt(1).code),   32'h184);
    check("s1_ip",     32'(pkt(1).ip),     32'h0004);
    check("s1_ipn",    32'(pkt(1).ipn),    32'h0006);
    check("s1_seg",    32'(pkt(1).seg),    32'd3);
    check("s1_rep",    32'(pkt(1).rep),    32'd0);
    check("s2_code",   32'(pkt(2).code),   32'h090);
    check("s2_opsize", 32'(pkt(2).opsize), 32'd1);
    check("s2_adsize", 32'(pkt(2).adsize), 32'd1);
    check("s2_lock",   32'(pkt(2).lock),   32'd1);
    check("s2_ip",     32'(pkt(2).ip),     32'h0006);
    check("s2_ipn",    32'(pkt(2).ipn),    32'h000A);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("order_code_%0d", i), 32'(pkt(3 + i).code), 32'h040 + 32'(i));
      check($sformatf("order_ip_%0d", i),   32'(pkt(3 + i).ip),   32'h00A + 32'(i));
    end

    if_flag = 1'b1; intr = 1'b1; irq = 8'h08;
    do_flush(16'h0080);
    cyc(30);
    check("irq_count", 32'(pk.size() - base), 32'd1);
    check("irq_kind",  32'(pkt(0).kind),      32'd1);
    check("irq_vec",   32'(pkt(0).vec),       32'h08);
    check("irq_ip",    32'(pkt(0).ip),        32'h0080);
    check("irq_intl",  32'(intl),             32'd1);

    if_flag = 1'b0;
    do_flush(16'h00A0);
    cyc(40);
    check("fault_count", 32'(pk.size() - base), 32'd1);
    check("fault_kind",  32'(pkt(0).kind),      32'd3);
    check("fault_ip",    32'(pkt(0).ip),        32'h00A0);
    check("hold_no_req", 32'(bus.mem_req),      32'd0);

    mem_stall = 1'b1;
    do_flush(16'h00C0);
    cyc(3);
    check("stale_req_out",  32'(bus.mem_req),  32'd1);
    check("stale_req_addr", bus.mem_addr,      32'h000000C0);
    do_flush(16'h00D0);
    mem_stall = 1'b0;
    cyc(30);
    check("stale_p0_code", 32'(pkt(0).code), 32'h060);
    check("stale_p0_ip",   32'(pkt(0).ip),   32'h00D0);
    check("stale_p1_code", 32'(pkt(1).code), 32'h061);

    tf_flag = 1'b1;
    do_flush(16'h00E0);
    cyc(20);
    check("tr_p0_kind", 32'(pkt(0).kind), 32'd0);
    check("tr_p0_code", 32'(pkt(0).code), 32'h040);
`ifdef FETCH_TRACE_EN
    check("tr_count",   32'(pk.size() - base), 32'd2);
    check("tr_p1_kind", 32'(pkt(1).kind),      32'd2);
    check("tr_p1_vec",  32'(pkt(1).vec),       32'h01);
    check("tr_p1_ip",   32'(pkt(1).ip),        32'h00E1);
`else
    check("tr_p1_kind", 32'(pkt(1).kind), 32'd0);
    check("tr_p1_code", 32'(pkt(1).code), 32'h041);
    check("tr_p2_code", 32'(pkt(2).code), 32'h042);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
